gemm_seq_ctrl: RTL and testbench
================================

# gemm_seq_ctrl

Loop sequencer for the GEMM accelerator: on `start` it latches the matrix dimensions and base addresses, then walks the output matrix element by element. For each element it issues a stream of operand-fetch requests to the MAC datapath and one result-write address. When the matrix is finished it pulses `fin`. It sits between the NICE instruction interface, which supplies parameters and `start` and consumes `state` and `fin`, and the MAC/memory datapath.

## Interface
Parameters:
- `DIM_W`, 16 — width of the dimension counters; only the low `DIM_W` bits of each 32-bit dimension input are used.
- `ADDR_W`, 32 — address width.

Ports:
- `nice_clk`  in  1  clock.
- `nice_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle launch pulse.
- `lhs_rows`, `rhs_rows`, `rhs_cols`  in  32 each  M, N, K. K is the dot-product length.
- `lhs_addr`, `rhs_addr`, `dst_addr`  in  ADDR_W each  byte base addresses of int8 row-major matrices.
- `state`  out  2  controller state; 2'b00 means idle and ready for a new instruction.
- `fin`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `fin`, when the launch had a zero dimension.
- `op_valid`  out  1  / `op_ready`  in  1  operand-fetch handshake.
- `op_lhs_addr`, `op_rhs_addr`  out  ADDR_W each  operand addresses.
- `op_first`, `op_last`  out  1 each  first / last beat of a dot product.
- `res_valid`  in  1  / `res_ready`  out  1  accumulator result handshake.
- `wr_valid`  out  1  / `wr_ready`  in  1  / `wr_addr`  out  ADDR_W  result-write handshake and address.

## Operation
- States: IDLE = 00, FETCH = 01, WRITE = 10, DONE = 11. The `state` output is the state register.
- **IDLE:** on `start`, latch all six parameters.
  - If any of M, N, K (low `DIM_W` bits) is zero, go to DONE with the error flag set.
  - Otherwise clear i, j, k and go to FETCH.
  - `start` is ignored in every other state.
- **FETCH:** assert `op_valid` with:
  - `op_lhs_addr` = lhs_addr + i·K + k
  - `op_rhs_addr` = rhs_addr + j·K + k
  - `op_first` = (k == 0)
  - `op_last` = (k == K−1)
  - On `op_valid & op_ready`, k increments. After the beat with k == K−1, clear k and go to WRITE.
- **WRITE:**
  - `wr_valid` = `res_valid`; `wr_addr` = dst_addr + i·N + j; `res_ready` = `wr_ready`.
  - On `res_valid & wr_ready`: if j < N−1, increment j and go to FETCH. Otherwise, if i < M−1, clear j, increment i and go to FETCH. Otherwise go to DONE.
- **DONE:** for one cycle, `fin` = 1 and `err` = the latched error flag; then go to IDLE.
- Loop order: i outer, j middle, k inner.
- Addresses are computed incrementally with no multipliers. Keep row-base registers `lhs_base` and `rhs_base`, each advanced by K, plus a `dst_ptr` advanced by 1 per write. All address arithmetic is modulo 2^ADDR_W.

## Timing
- Reset values: `state` = 00, and `fin`, `err`, `op_valid`, `op_first`, `op_last`, `res_ready`, `wr_valid` = 0. All address outputs = 0.
- Latency: `start` at cycle t gives the first `op_valid` at t+1. A zero-dimension launch gives `fin`/`err` at t+1. The last write handshake at cycle t gives `fin` at t+1, and `state` = 00 at t+2.
- Handshake stability: while `op_valid` is high and `op_ready` is low, the operand payload and flags stay stable. `op_valid` never drops without a handshake.
- With `op_ready` held high, exactly one beat completes per cycle and there are no bubbles inside a dot product.
- K == 1: every beat has both `op_first` and `op_last` set.
- Asserting `nice_rst_n` low mid-run returns the block to IDLE with all outputs at reset values immediately (asynchronous). No `fin` is produced.
- `start` coinciding with the DONE cycle is ignored.

## Structure
- Shared package `gemm_pkg`: state encoding localparams (`GEMM_IDLE`, `GEMM_FETCH`, `GEMM_WRITE`, `GEMM_DONE`) and the `DIM_W` default. The instruction interface and the datapath use the same state encoding.
- One sub-module is natural: `gemm_dim_counter`, a `DIM_W` counter with clear, enable, limit input and a `last` flag. It is instantiated three times, for i, j and k.

## Test plan
- **Basic 2×2×3:** M=2, N=2, K=3, lhs=0x1000, rhs=0x2000, dst=0x3000, all ready signals high.
  - 12 operand beats. First dot product: (0x1000,0x2000) first, then (0x1001,0x2001), then (0x1002,0x2002) last. Third dot product starts at (0x1003,0x2000).
  - 4 writes at 0x3000, 0x3001, 0x3002, 0x3003.
  - One `fin`, `err` = 0.
- **Backpressure:** same run with `op_ready` and `wr_ready` randomly low. Payload holds stable while stalled; beat and write sequences are identical to the basic case.
- **Zero dimension:** `rhs_cols` = 0. `fin` and `err` = 1 at t+1; no `op_valid`, no `wr_valid`.
- **Minimal 1×1×1:** a single beat with `op_first` = `op_last` = 1, a single write to `dst_addr`, then `fin`.
- **Start while busy:** a second `start` during FETCH is ignored; only one `fin` is produced and the latched parameters are unchanged.
- **Reset mid-run:** drop `nice_rst_n` during WRITE. Outputs return to reset values at once, there is no `fin`, and a new `start` runs cleanly.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM loop sequencer: state encoding common to the
// instruction interface and datapath, plus default widths.
package gemm_pkg;

  localparam logic [1:0] GEMM_IDLE  = 2'b00;
  localparam logic [1:0] GEMM_FETCH = 2'b01;
  localparam logic [1:0] GEMM_WRITE = 2'b10;
  localparam logic [1:0] GEMM_DONE  = 2'b11;

  localparam int GEMM_DIM_W  = 16;
  localparam int GEMM_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = GEMM_IDLE,
    ST_FETCH = GEMM_FETCH,
    ST_WRITE = GEMM_WRITE,
    ST_DONE  = GEMM_DONE
  } gemm_state_e;

endpackage

// File: rtl/gemm_dim_counter.sv
// Loop index counter: counts 0..limit-1 on enable, wraps to zero after the
// last value, and flags when it sits on limit-1.
module gemm_dim_counter
  import gemm_pkg::*;
#(
  parameter int DIM_W = GEMM_DIM_W
) (
  input  logic             nice_clk,
  input  logic             nice_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] limit,
  output logic [DIM_W-1:0] cnt,
  output logic             last
);

  logic [DIM_W-1:0] cnt_q;
  logic [DIM_W-1:0] cnt_d;

  assign last = (cnt_q == (limit - DIM_W'(1)));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (en)   cnt_d = last ? '0 : cnt_q + DIM_W'(1);
  end

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gemm_seq_ctrl.sv
// GEMM loop sequencer: walks C[i][j] = sum_k A[i][k]*B[j][k], issuing operand
// fetch beats per dot product and one result write per output element.
//
// state | meaning
// IDLE  | waiting for start; parameters latched on start
// FETCH | streaming K operand beats for element (i,j)
// WRITE | passing accumulator result to memory at dst + i*N + j
// DONE  | one-cycle fin (and err if a dimension was zero)
module gemm_seq_ctrl
  import gemm_pkg::*;
#(
  parameter int DIM_W  = GEMM_DIM_W,
  parameter int ADDR_W = GEMM_ADDR_W
) (
  input  logic              nice_clk,
  input  logic              nice_rst_n,
  input  logic              start,
  input  logic [31:0]       lhs_rows,
  input  logic [31:0]       rhs_rows,
  input  logic [31:0]       rhs_cols,
  input  logic [ADDR_W-1:0] lhs_addr,
  input  logic [ADDR_W-1:0] rhs_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [1:0]        state,
  output logic              fin,
  output logic              err,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_lhs_addr,
  output logic [ADDR_W-1:0] op_rhs_addr,
  output logic              op_first,
  output logic              op_last,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr
);

  gemm_state_e       state_q;
  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic [ADDR_W-1:0] rhs_addr_q;
  logic [ADDR_W-1:0] lhs_base_q, rhs_base_q, dst_ptr_q;
  logic              err_q;

  logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
  logic              i_last, j_last, k_last;
  logic              in_idle, in_fetch, in_write, in_done;
  logic              launch, zero_dim, op_fire, wr_fire;
  logic [ADDR_W-1:0] k_ext;
  logic              unused_dim_hi;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_fetch = (state_q == ST_FETCH);
  assign in_write = (state_q == ST_WRITE);
  assign in_done  = (state_q == ST_DONE);

  assign launch   = in_idle & start;
  assign zero_dim = (lhs_rows[DIM_W-1:0] == '0) | (rhs_rows[DIM_W-1:0] == '0) |
                    (rhs_cols[DIM_W-1:0] == '0);
  assign op_fire  = in_fetch & op_ready;
  assign wr_fire  = in_write & res_valid & wr_ready;
  assign k_ext    = {{(ADDR_W-DIM_W){1'b0}}, k_q};

  // Upper dimension bits are architecturally ignored; i/j values only matter via their last flags.
  assign unused_dim_hi = ^{lhs_rows[31:DIM_W], rhs_rows[31:DIM_W], rhs_cols[31:DIM_W], i_cnt, j_cnt};

  gemm_dim_counter #(.DIM_W(DIM_W)) u_cnt_i (
    .nice_clk   (nice_clk),
    .nice_rst_n (nice_rst_n),
    .clr        (launch),
    .en         (wr_fire & j_last),
    .limit      (m_q),
    .cnt        (i_cnt),
    .last       (i_last)
  );

  gemm_dim_counter #(.DIM_W(DIM_W)) u_cnt_j (
    .nice_clk   (nice_clk),
    .nice_rst_n (nice_rst_n),
    .clr        (launch),
    .en         (wr_fire),
    .limit      (n_q),
    .cnt        (j_cnt),
    .last       (j_last)
  );

  gemm_dim_counter #(.DIM_W(DIM_W)) u_cnt_k (
    .nice_clk   (nice_clk),
    .nice_rst_n (nice_rst_n),
    .clr        (launch),
    .en         (op_fire),
    .limit      (k_q),
    .cnt        (k_cnt),
    .last       (k_last)
  );

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      rhs_addr_q <= '0;
      lhs_base_q <= '0;
      rhs_base_q <= '0;
      dst_ptr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            m_q        <= lhs_rows[DIM_W-1:0];
            n_q        <= rhs_rows[DIM_W-1:0];
            k_q        <= rhs_cols[DIM_W-1:0];
            rhs_addr_q <= rhs_addr;
            lhs_base_q <= lhs_addr;
            rhs_base_q <= rhs_addr;
            dst_ptr_q  <= dst_addr;
            err_q      <= zero_dim;
            state_q    <= zero_dim ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (op_ready && k_last) state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (res_valid && wr_ready) begin
            dst_ptr_q <= dst_ptr_q + ADDR_W'(1);
            if (j_last) begin
              // End of an output row: B restarts at row 0, A moves to the next row.
              rhs_base_q <= rhs_addr_q;
              if (i_last) begin
                state_q <= ST_DONE;
              end else begin
                lhs_base_q <= lhs_base_q + k_ext;
                state_q    <= ST_FETCH;
              end
            end else begin
              rhs_base_q <= rhs_base_q + k_ext;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign fin         = in_done;
  assign err         = in_done & err_q;
  assign op_valid    = in_fetch;
  assign op_first    = in_fetch & (k_cnt == '0);
  assign op_last     = in_fetch & k_last;
  assign op_lhs_addr = lhs_base_q + {{(ADDR_W-DIM_W){1'b0}}, k_cnt};
  assign op_rhs_addr = rhs_base_q + {{(ADDR_W-DIM_W){1'b0}}, k_cnt};
  assign wr_valid    = in_write & res_valid;
  assign res_ready   = in_write & wr_ready;
  assign wr_addr     = dst_ptr_q;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Directed bench for gemm_seq_ctrl: hand-computed beat/write tables checked
// with immediate assertions, sampled on the falling clock edge.
module tb_gemm_seq_ctrl;

  logic        nice_clk = 1'b0;
  logic        nice_rst_n;
  logic        start;
  logic [31:0] lhs_rows, rhs_rows, rhs_cols;
  logic [31:0] lhs_addr, rhs_addr, dst_addr;
  logic [1:0]  state;
  logic        fin, err;
  logic        op_valid, op_ready;
  logic [31:0] op_lhs_addr, op_rhs_addr;
  logic        op_first, op_last;
  logic        res_valid, res_ready;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr;

  int vec = 0;
  int mis = 0;

  logic [31:0] exp_l [12];
  logic [31:0] exp_r [12];
  logic        exp_f [12];
  logic        exp_z [12];
  logic [31:0] exp_w [4];

  always #5 nice_clk = ~nice_clk;

  gemm_seq_ctrl dut (
    .nice_clk    (nice_clk),
    .nice_rst_n  (nice_rst_n),
    .start       (start),
    .lhs_rows    (lhs_rows),
    .rhs_rows    (rhs_rows),
    .rhs_cols    (rhs_cols),
    .lhs_addr    (lhs_addr),
    .rhs_addr    (rhs_addr),
    .dst_addr    (dst_addr),
    .state       (state),
    .fin         (fin),
    .err         (err),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_lhs_addr (op_lhs_addr),
    .op_rhs_addr (op_rhs_addr),
    .op_first    (op_first),
    .op_last     (op_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_basic();
    lhs_rows = 32'd2; rhs_rows = 32'd2; rhs_cols = 32'd3;
    lhs_addr = 32'h1000; rhs_addr = 32'h2000; dst_addr = 32'h3000;
    exp_l = '{32'h1000, 32'h1001, 32'h1002, 32'h1000, 32'h1001, 32'h1002,
              32'h1003, 32'h1004, 32'h1005, 32'h1003, 32'h1004, 32'h1005};
    exp_r = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2004, 32'h2005,
              32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2004, 32'h2005};
    exp_f = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_z = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_w = '{32'h3000, 32'h3001, 32'h3002, 32'h3003};
  endtask

  task automatic set_min();
    lhs_rows = 32'd1; rhs_rows = 32'd1; rhs_cols = 32'd1;
    lhs_addr = 32'h4000; rhs_addr = 32'h5000; dst_addr = 32'h6000;
    exp_l[0] = 32'h4000; exp_r[0] = 32'h5000; exp_f[0] = 1'b1; exp_z[0] = 1'b1;
    exp_w[0] = 32'h6000;
  endtask

  // Launch, then run until fin, checking every beat and write against the tables.
  task automatic run_mat(input bit bp, input int nb, input int nw, input bit exp_err,
                         input bit busy_start, input bit done_start);
    int beat, wr, fins;
    logic stall, pf, pz;
    logic [31:0] pl, pr;
    beat = 0; wr = 0; fins = 0; stall = 1'b0;
    pf = 1'b0; pz = 1'b0; pl = '0; pr = '0;
    @(negedge nice_clk); start = 1'b1;
    @(negedge nice_clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && fins == 0; cyc++) begin
      if (cyc > 0) @(negedge nice_clk);
      if (busy_start && cyc == 1) begin
        start = 1'b1;
        lhs_rows = 32'd1; rhs_rows = 32'd1; rhs_cols = 32'd1;
        lhs_addr = 32'h9000; rhs_addr = 32'h9100; dst_addr = 32'h9200;
      end else begin
        start = 1'b0;
      end
      op_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      res_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) begin
        chk("launch_op_valid", {31'd0, op_valid}, {31'd0, nb > 0});
        chk("launch_fin", {31'd0, fin}, {31'd0, exp_err});
      end
      if (stall) begin
        chk("stall_valid", {31'd0, op_valid}, 32'd1);
        chk("stall_lhs", op_lhs_addr, pl);
        chk("stall_rhs", op_rhs_addr, pr);
        chk("stall_flags", {30'd0, op_first, op_last}, {30'd0, pf, pz});
      end
      if (op_valid && op_ready) begin
        if (beat < nb) begin
          chk($sformatf("beat%0d_lhs", beat), op_lhs_addr, exp_l[beat]);
          chk($sformatf("beat%0d_rhs", beat), op_rhs_addr, exp_r[beat]);
          chk($sformatf("beat%0d_flags", beat), {30'd0, op_first, op_last},
              {30'd0, exp_f[beat], exp_z[beat]});
        end
        beat++;
      end
      stall = op_valid && !op_ready;
      pl = op_lhs_addr; pr = op_rhs_addr; pf = op_first; pz = op_last;
      if (state == 2'b10) begin
        chk("wr_valid_follow", {31'd0, wr_valid}, {31'd0, res_valid});
        chk("res_ready_follow", {31'd0, res_ready}, {31'd0, wr_ready});
      end
      if (wr_valid && wr_ready) begin
        if (wr < nw) chk($sformatf("write%0d_addr", wr), wr_addr, exp_w[wr]);
        wr++;
      end
      if (fin) begin
        fins++;
        chk("fin_err", {31'd0, err}, {31'd0, exp_err});
      end
    end
    chk("fin_seen", fins, 1);
    chk("beat_count", beat, nb);
    chk("write_count", wr, nw);
    if (done_start) start = 1'b1;
    @(negedge nice_clk); start = 1'b0; #1;
    chk("idle_after_fin", {30'd0, state}, 32'd0);
    chk("fin_one_cycle", {31'd0, fin}, 32'd0);
    @(negedge nice_clk); #1;
    chk("still_idle", {30'd0, state}, 32'd0);
    chk("no_op_after_fin", {31'd0, op_valid}, 32'd0);
  endtask

  initial begin
    int waited;
    int fins;
    nice_rst_n = 1'b0; start = 1'b0;
    lhs_rows = '0; rhs_rows = '0; rhs_cols = '0;
    lhs_addr = '0; rhs_addr = '0; dst_addr = '0;
    op_ready = 1'b0; res_valid = 1'b0; wr_ready = 1'b0;
    repeat (2) @(negedge nice_clk);
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_flags", {25'd0, fin, err, op_valid, op_first, op_last, res_ready, wr_valid}, 32'd0);
    chk("rst_addrs", op_lhs_addr | op_rhs_addr | wr_addr, 32'd0);
    @(negedge nice_clk); nice_rst_n = 1'b1;

    set_basic();
    run_mat(1'b0, 12, 4, 1'b0, 1'b0, 1'b1);

    set_basic();
    run_mat(1'b1, 12, 4, 1'b0, 1'b0, 1'b0);

    set_basic();
    rhs_cols = 32'h0001_0000;
    run_mat(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

    set_min();
    run_mat(1'b0, 1, 1, 1'b0, 1'b0, 1'b0);

    set_basic();
    run_mat(1'b0, 12, 4, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of WRITE with the write side stalled.
    set_basic();
    op_ready = 1'b1; wr_ready = 1'b0; res_valid = 1'b1;
    @(negedge nice_clk); start = 1'b1;
    @(negedge nice_clk); start = 1'b0;
    waited = 0;
    while (state != 2'b10 && waited < 20) begin
      @(negedge nice_clk);
      waited++;
    end
    chk("reach_write", {30'd0, state}, 32'd2);
    #2 nice_rst_n = 1'b0;
    #1;
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_flags", {25'd0, fin, err, op_valid, op_first, op_last, res_ready, wr_valid}, 32'd0);
    chk("midrst_addrs", op_lhs_addr | op_rhs_addr | wr_addr, 32'd0);
    @(negedge nice_clk); nice_rst_n = 1'b1;
    fins = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge nice_clk); #1;
      if (fin) fins++;
    end
    chk("midrst_no_fin", fins, 0);

    set_min();
    run_mat(1'b0, 1, 1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
